mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//   Load/store sequencer directly upstream of the word-wide data memory M.
//   Accepts one core request at a time and drives M's read/write controls.
//   Handles byte/halfword loads (extract + sign/zero extend) and sub-word
//   stores (read-modify-write, since M writes whole words only).
//   Returns one response per request through a valid/ready handshake.
// PARAMETERS
//   MEM_ADDR_WIDTH  8   word-index width of M; M decodes addr[MEM_ADDR_WIDTH+1:2]
//   ADDR_WIDTH      32  byte address width of core requests
// PORTS
//   clk        in   1    single clock; all state on posedge
//   rst_n      in   1    asynchronous, active-low reset
//   req_valid  in   1    core request present
//   req_ready  out  1    unit can accept; 1 only in IDLE
//   req_op     in   3    0 LW, 1 LH, 2 LHU, 3 LB, 4 LBU, 5 SW, 6 SH, 7 SB
//   req_addr   in   32   byte address
//   req_wdata  in   32   store data; SH uses [15:0], SB uses [7:0]
//   rsp_valid  out  1    response present; held until accepted
//   rsp_ready  in   1    core accepts response
//   rsp_rdata  out  32   load result, extended; 0 for stores and errors
//   rsp_err    out  1    misaligned or out-of-range; M never accessed
//   m_read     out  1    to M read enable (1 = ENABLE)
//   m_write    out  1    to M write enable (1 = ENABLE)
//   m_addr     out  32   to M addr; word-aligned, bits [1:0] always 0
//   m_wdata    out  32   to M write value
//   m_rdata    in   32   from M; combinational, valid while m_read=1
// BEHAVIOUR
//   Reset: state IDLE; req_ready=1 after reset; rsp_valid, rsp_err,
//     m_read, m_write = 0; rsp_rdata, m_addr, m_wdata = 0.
//   Accept: req_valid & req_ready at a posedge captures op/addr/wdata.
//     Inputs are ignored outside IDLE.
//   FSM: IDLE, READ, WRITE, RESP.
//   Errors, checked at accept:
//     - misaligned: LW/SW with addr[1:0]!=0; LH/LHU/SH with addr[0]!=0
//     - out-of-range: any addr bit at or above MEM_ADDR_WIDTH+2 is 1
//     Error -> RESP with rsp_err=1, rsp_rdata=0, no M access.
//   State sequences:
//     - loads: IDLE -> READ -> RESP
//     - SW: IDLE -> WRITE -> RESP
//     - SH/SB: IDLE -> READ -> WRITE -> RESP
//   READ: m_read=1 for exactly one cycle. m_rdata is registered at the
//     exiting edge.
//   Lanes are little-endian; byte lane = addr[1:0], halfword = addr[1].
//   Loads: LH/LB sign-extend; LHU/LBU zero-extend; LW passes the word.
//   WRITE: m_write=1 for exactly one cycle. m_wdata depends on op:
//     - SW: req_wdata
//     - SH/SB: the captured word with the addressed lane replaced
//   m_addr is held for the whole READ..WRITE span. m_read and m_write are
//     never 1 together. Both are 0 in IDLE and RESP.
//   RESP: rsp_valid=1 and outputs stable until rsp_valid&rsp_ready; then
//     IDLE. No pipelining: next accept is no earlier than the cycle after.
//   Latency, from accept edge N to rsp_valid high:
//     - LW/loads: N+2 (READ in N+1)
//     - SW: N+2
//     - SH/SB: N+3
//     - error: N+1
//   Reset mid-op: immediate return to IDLE with outputs at reset values.
//     An in-flight WRITE is dropped; M sees no write after rst_n falls.
//     A pending response is discarded.
// TESTING
//   SW 0xDEADBEEF @0x10, then LW @0x10 -> rsp_rdata=0xDEADBEEF, one m_write pulse
//   word@0x20=0x8899AABB; LB @0x21 -> 0xFFFFFFAA; LBU @0x21 -> 0x000000AA; LH @0x22 -> 0xFFFF8899
//   word@0x20=0x8899AABB; SB 0x55 @0x22 -> M word 0x8855AABB; rsp_valid at N+3; READ then WRITE observed
//   LW @0x13 or SH @0x11 or LW @0x400 (MEM_ADDR_WIDTH=8) -> rsp_err=1, m_read=m_write=0 throughout
//   rsp_ready held 0 for 5 cycles -> rsp_valid/rsp_rdata stable, req_ready=0, new req_valid ignored
//   rst_n low during WRITE of SH -> m_write drops at once, M word unchanged, req_ready=1 after release

Source files
------------

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store sequencer in front of word-wide data memory M.
// One request at a time; sub-word stores use read-modify-write, sub-word
// loads are lane-extracted and sign/zero extended.
module mem_access_unit #(
  parameter int MEM_ADDR_WIDTH = 8,
  parameter int ADDR_WIDTH     = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [2:0]            req_op,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err,
  output logic                  m_read,
  output logic                  m_write,
  output logic [ADDR_WIDTH-1:0] m_addr,
  output logic [31:0]           m_wdata,
  input  logic [31:0]           m_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_RESP} state_t;
  typedef enum logic [2:0] {
    OP_LW, OP_LH, OP_LHU, OP_LB, OP_LBU, OP_SW, OP_SH, OP_SB
  } op_t;

  // Any set bit in this mask lies beyond the memory's byte range.
  localparam logic [ADDR_WIDTH-1:0] HI_MASK =
    ~((ADDR_WIDTH'(1) << (MEM_ADDR_WIDTH + 2)) - ADDR_WIDTH'(1));

  state_t      state;
  op_t         op_q;
  logic [1:0]  lane_q;
  logic [15:0] wdata_q;

  op_t         req_op_e;
  logic        misaligned;
  logic        out_of_range;
  logic [31:0] byte_shift;
  logic [31:0] half_shift;
  logic [31:0] load_data;
  logic [31:0] merged;

  assign req_op_e = op_t'(req_op);

  // Request validity checks, evaluated against the live request in IDLE.
  always_comb begin
    misaligned = 1'b0;
    case (req_op_e)
      OP_LW, OP_SW:         misaligned = (req_addr[1:0] != 2'b00);
      OP_LH, OP_LHU, OP_SH: misaligned = req_addr[0];
      default:              misaligned = 1'b0;
    endcase
    out_of_range = |(req_addr & HI_MASK);
  end

  assign byte_shift = m_rdata >> {lane_q, 3'b000};
  assign half_shift = m_rdata >> {lane_q[1], 4'b0000};

  // Lane extraction and extension of the word returned by M.
  always_comb begin
    load_data = m_rdata;
    case (op_q)
      OP_LH:   load_data = {{16{half_shift[15]}}, half_shift[15:0]};
      OP_LHU:  load_data = {16'h0000, half_shift[15:0]};
      OP_LB:   load_data = {{24{byte_shift[7]}}, byte_shift[7:0]};
      OP_LBU:  load_data = {24'h000000, byte_shift[7:0]};
      default: load_data = m_rdata;
    endcase
  end

  // Read-modify-write merge: replace only the addressed lane of the word.
  always_comb begin
    merged = m_rdata;
    if (op_q == OP_SH) begin
      merged[{lane_q[1], 4'b0000} +: 16] = wdata_q;
    end else if (op_q == OP_SB) begin
      merged[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
    end
  end

  // Sequencer FSM; all core- and memory-facing outputs are registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      op_q      <= OP_LW;
      lane_q    <= '0;
      wdata_q   <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      m_read    <= 1'b0;
      m_write   <= 1'b0;
      m_addr    <= '0;
      m_wdata   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            op_q      <= req_op_e;
            lane_q    <= req_addr[1:0];
            wdata_q   <= req_wdata[15:0];
            req_ready <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            if (misaligned || out_of_range) begin
              rsp_err   <= 1'b1;
              rsp_valid <= 1'b1;
              state     <= S_RESP;
            end else begin
              m_addr <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
              if (req_op_e == OP_SW) begin
                m_wdata <= req_wdata;
                m_write <= 1'b1;
                state   <= S_WRITE;
              end else begin
                m_read <= 1'b1;
                state  <= S_READ;
              end
            end
          end
        end
        S_READ: begin
          m_read <= 1'b0;
          if (op_q == OP_SH || op_q == OP_SB) begin
            m_wdata <= merged;
            m_write <= 1'b1;
            state   <= S_WRITE;
          end else begin
            rsp_rdata <= load_data;
            rsp_valid <= 1'b1;
            state     <= S_RESP;
          end
        end
        S_WRITE: begin
          m_write   <= 1'b0;
          rsp_valid <= 1'b1;
          state     <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit with a behavioural
// word memory attached to the M port.
module tb_mem_access_unit;

  localparam logic [2:0] LW = 3'd0, LH = 3'd1, LHU = 3'd2, LB = 3'd3,
                         LBU = 3'd4, SW = 3'd5, SH = 3'd6, SB = 3'd7;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_op = '0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        m_read;
  logic        m_write;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;

  logic [31:0] mem [256];
  int tests = 0;
  int fails = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;
  int both_cnt = 0;

  mem_access_unit #(.MEM_ADDR_WIDTH(8), .ADDR_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .m_read(m_read), .m_write(m_write), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  assign m_rdata = mem[m_addr[9:2]];

  always @(posedge clk) begin
    if (m_read) rd_cnt++;
    if (m_write) begin
      wr_cnt++;
      mem[m_addr[9:2]] <= m_wdata;
    end
    if (m_read && m_write) both_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One full transaction: accept, wait (bounded) for response, handshake.
  task automatic issue(input logic [2:0] op, input logic [31:0] addr,
                       input logic [31:0] wdata, output int lat,
                       output logic [31:0] rdata, output logic err,
                       output int rd_d, output int wr_d);
    int rd0, wr0;
    @(negedge clk);
    chk("req_ready_before_issue", {31'b0, req_ready}, 32'd1);
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    req_wdata = wdata;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    lat = 1;
    while (rsp_valid !== 1'b1 && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    rdata = rsp_rdata;
    err   = rsp_err;
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    rd_d = rd_cnt - rd0;
    wr_d = wr_cnt - wr0;
  endtask

  task automatic run_load(input string tag, input logic [2:0] op,
                          input logic [31:0] addr, input logic [31:0] exp);
    int lat, rd_d, wr_d;
    logic [31:0] rdata;
    logic err;
    issue(op, addr, 32'h0, lat, rdata, err, rd_d, wr_d);
    chk({tag, "_rdata"}, rdata, exp);
    chk({tag, "_lat"}, lat, 32'd2);
    chk({tag, "_err"}, {31'b0, err}, 32'd0);
    chk({tag, "_reads"}, rd_d, 32'd1);
    chk({tag, "_writes"}, wr_d, 32'd0);
  endtask

  task automatic run_err(input string tag, input logic [2:0] op, input logic [31:0] addr);
    int lat, rd_d, wr_d;
    logic [31:0] rdata;
    logic err;
    issue(op, addr, 32'h12345678, lat, rdata, err, rd_d, wr_d);
    chk({tag, "_err"}, {31'b0, err}, 32'd1);
    chk({tag, "_rdata"}, rdata, 32'd0);
    chk({tag, "_lat"}, lat, 32'd1);
    chk({tag, "_mem_access"}, rd_d + wr_d, 32'd0);
  endtask

  initial begin
    int lat, rd_d, wr_d, wr0;
    logic [31:0] rdata;
    logic err;

    // Reset values
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_rsp_err",   {31'b0, rsp_err},   32'd0);
    chk("rst_m_read",    {31'b0, m_read},    32'd0);
    chk("rst_m_write",   {31'b0, m_write},   32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_m_addr",    m_addr,    32'd0);
    chk("rst_m_wdata",   m_wdata,   32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // SW then LW of the same word
    issue(SW, 32'h10, 32'hDEADBEEF, lat, rdata, err, rd_d, wr_d);
    chk("sw_lat", lat, 32'd2);
    chk("sw_rdata", rdata, 32'd0);
    chk("sw_err", {31'b0, err}, 32'd0);
    chk("sw_writes", wr_d, 32'd1);
    chk("sw_reads", rd_d, 32'd0);
    chk("sw_mem", mem[4], 32'hDEADBEEF);
    run_load("lw10", LW, 32'h10, 32'hDEADBEEF);

    // Sub-word loads from 0x8899AABB
    issue(SW, 32'h20, 32'h8899AABB, lat, rdata, err, rd_d, wr_d);
    chk("sw20_mem", mem[8], 32'h8899AABB);
    run_load("lb21",  LB,  32'h21, 32'hFFFFFFAA);
    run_load("lbu21", LBU, 32'h21, 32'h000000AA);
    run_load("lh22",  LH,  32'h22, 32'hFFFF8899);
    run_load("lhu20", LHU, 32'h20, 32'h0000AABB);
    run_load("lh20",  LH,  32'h20, 32'hFFFFAABB);
    run_load("lb23",  LB,  32'h23, 32'hFFFFFF88);
    run_load("lbu20", LBU, 32'h20, 32'h000000BB);

    // SB 0x55 @0x22, stepped cycle by cycle
    @(negedge clk);
    req_valid = 1'b1; req_op = SB; req_addr = 32'h22; req_wdata = 32'hFFFFFF55;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk("sb_c1_m_read",  {31'b0, m_read},  32'd1);
    chk("sb_c1_m_write", {31'b0, m_write}, 32'd0);
    chk("sb_c1_m_addr",  m_addr, 32'h20);
    chk("sb_c1_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    @(posedge clk);
    #1;
    chk("sb_c2_m_read",  {31'b0, m_read},  32'd0);
    chk("sb_c2_m_write", {31'b0, m_write}, 32'd1);
    chk("sb_c2_m_addr",  m_addr, 32'h20);
    chk("sb_c2_m_wdata", m_wdata, 32'h8855AABB);
    chk("sb_c2_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    @(posedge clk);
    #1;
    chk("sb_c3_rsp_valid", {31'b0, rsp_valid}, 32'd1);
    chk("sb_c3_m_write", {31'b0, m_write}, 32'd0);
    chk("sb_c3_rsp_rdata", rsp_rdata, 32'd0);
    chk("sb_c3_rsp_err", {31'b0, rsp_err}, 32'd0);
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    chk("sb_mem", mem[8], 32'h8855AABB);

    // SH upper halfword
    issue(SH, 32'h12, 32'hAAAA1234, lat, rdata, err, rd_d, wr_d);
    chk("sh12_lat", lat, 32'd3);
    chk("sh12_rw", {rd_d[15:0], wr_d[15:0]}, 32'h0001_0001);
    chk("sh12_mem", mem[4], 32'h1234BEEF);

    // Error cases
    run_err("lw13_misaligned", LW, 32'h13);
    run_err("sh11_misaligned", SH, 32'h11);
    run_err("lw400_range", LW, 32'h400);
    run_err("sb_hi_range", SB, 32'h8000_0010);

    // Response backpressure with a competing request
    wr0 = wr_cnt;
    @(negedge clk);
    req_valid = 1'b1; req_op = LW; req_addr = 32'h20;
    @(posedge clk);
    #1;
    req_op = SW; req_addr = 32'h20; req_wdata = 32'h0;
    @(posedge clk);
    #1;
    chk("bp_first_valid", {31'b0, rsp_valid}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("bp_rsp_valid", {31'b0, rsp_valid}, 32'd1);
      chk("bp_rsp_rdata", rsp_rdata, 32'h8855AABB);
      chk("bp_req_ready", {31'b0, req_ready}, 32'd0);
    end
    @(negedge clk);
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    chk("bp_done_valid", {31'b0, rsp_valid}, 32'd0);
    chk("bp_done_ready", {31'b0, req_ready}, 32'd1);
    chk("bp_no_write", wr_cnt - wr0, 32'd0);
    chk("bp_mem", mem[8], 32'h8855AABB);

    // Reset asserted during the WRITE of an SH
    wr0 = wr_cnt;
    @(negedge clk);
    req_valid = 1'b1; req_op = SH; req_addr = 32'h10; req_wdata = 32'h0000CAFE;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk("rw_read", {31'b0, m_read}, 32'd1);
    @(posedge clk);
    #1;
    chk("rw_write", {31'b0, m_write}, 32'd1);
    chk("rw_wdata", m_wdata, 32'h1234CAFE);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rw_write_dropped", {31'b0, m_write}, 32'd0);
    chk("rw_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rw_m_addr", m_addr, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rw_req_ready", {31'b0, req_ready}, 32'd1);
    chk("rw_no_write", wr_cnt - wr0, 32'd0);
    chk("rw_mem", mem[4], 32'h1234BEEF);
    run_load("lw10_after_rst", LW, 32'h10, 32'h1234BEEF);

    chk("never_read_and_write", both_cnt, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
